// File: rtl/pipe_mmio_ctrl_if.sv
// CPU-side MMIO bus between the MEM stage and pipe_mmio_ctrl.
// Carries addr/re/we/wdata from the CPU and the registered load data back.
interface pipe_mmio_ctrl_if;
    logic [7:0]  addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output addr,
        output re,
        output we,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  re,
        input  we,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/pipe_mmio_ctrl.sv
// MMIO controller: debounced toggle/event switch registers, CPU output regs
// and a shared round-robin binary-to-BCD converter driving 2-digit displays.
// Ports: clock, reset (sync, active-high), sw (active-low raw switches),
// bus (slave side of the MMIO interface), led (toggle state), hex (segments).
module pipe_mmio_ctrl #(
    parameter int N_SW = 4,
    parameter int N_DISP = 3,
    parameter int DEB_CYCLES = 16,
    parameter logic [N_SW-1:0] TOGGLE_INIT = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_SW-1:0]       sw,
    pipe_mmio_ctrl_if.slave       bus,
    output logic [N_SW-1:0]       led,
    output logic [14*N_DISP-1:0]  hex
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [6:0] DASH = 7'b0111111;

    // Switch input path
    logic [N_SW-1:0] sync1;
    logic [N_SW-1:0] sync2;
    logic [N_SW-1:0] stable;
    logic [N_SW-1:0] toggle;
    logic [N_SW-1:0] events;
    logic [N_SW-1:0] hit;
    logic [N_SW-1:0] fall;
    logic [CW-1:0]   cnt [N_SW];

    always_comb begin
        hit  = '0;
        fall = '0;
        for (int i = 0; i < N_SW; i++) begin
            hit[i]  = (sync2[i] != stable[i]) &&
                      (cnt[i] == CW'(DEB_CYCLES - 1));
            fall[i] = hit[i] && !sync2[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1  <= '1;
            sync2  <= '1;
            stable <= '1;
            for (int i = 0; i < N_SW; i++) cnt[i] <= '0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            for (int i = 0; i < N_SW; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (hit[i]) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Bus decode
    logic [5:0]        word;
    logic              ev_sel;
    logic              ev_clr;
    logic [31:0]       rd_val;
    logic [31:0]       rdata_q;
    logic [31:0]       outr [N_DISP];
    logic [N_DISP-1:0] wr_sel;
    logic              unused_addr;

    assign word        = bus.addr[7:2];
    assign unused_addr = ^bus.addr[1:0];
    assign ev_sel      = (word == 6'h10);
    assign ev_clr      = bus.re && ev_sel;

    always_comb begin
        rd_val = '0;
        wr_sel = '0;
        for (int i = 0; i < N_SW; i++)
            if (word == 6'(i)) rd_val = {31'b0, toggle[i]};
        if (ev_sel) rd_val = 32'(events);
        for (int j = 0; j < N_DISP; j++) begin
            if (word == 6'(32 + j)) begin
                rd_val    = outr[j];
                wr_sel[j] = bus.we;
            end
        end
    end

    // rd_val comes from pre-edge state, so read+write returns the old value
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
            toggle  <= TOGGLE_INIT;
            events  <= '0;
            for (int j = 0; j < N_DISP; j++) outr[j] <= '0;
        end else begin
            if (bus.re) rdata_q <= rd_val;
            toggle <= toggle ^ fall;
            // a press landing with the clear keeps its bit set
            events <= (ev_clr ? '0 : events) | fall;
            for (int j = 0; j < N_DISP; j++)
                if (wr_sel[j]) outr[j] <= bus.wdata;
        end
    end

    assign bus.rdata = rdata_q;
    assign led       = toggle;

    // Converter FSM
    typedef enum logic [1:0] {
        S_LOAD,
        S_SHIFT,
        S_STORE
    } state_t;

    state_t state;
    state_t state_nx;
    logic   do_load;
    logic   do_shift;
    logic   do_store;

    logic [2:0]          ch;
    logic [2:0]          nsh;
    logic [6:0]          bin;
    logic [7:0]          bcd;
    logic [7:0]          adj;
    logic                over;
    logic [31:0]         cur;
    logic [14*N_DISP-1:0] hex_q;

    always_ff @(posedge clock) begin
        if (reset) state <= S_LOAD;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_LOAD:  state_nx = S_SHIFT;
            S_SHIFT: state_nx = (nsh == 3'd6) ? S_STORE : S_SHIFT;
            S_STORE: state_nx = S_LOAD;
            default: state_nx = S_LOAD;
        endcase
    end

    always_comb begin
        do_load  = (state == S_LOAD);
        do_shift = (state == S_SHIFT);
        do_store = (state == S_STORE);
    end

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        cur = '0;
        for (int j = 0; j < N_DISP; j++)
            if (ch == 3'(j)) cur = outr[j];
    end

    // Double-dabble: add 3 to any BCD nibble >= 5 before shifting
    always_comb begin
        adj = bcd;
        if (bcd[3:0] >= 4'd5) adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) adj[7:4] = bcd[7:4] + 4'd3;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ch    <= '0;
            nsh   <= '0;
            bin   <= '0;
            bcd   <= '0;
            over  <= 1'b0;
            hex_q <= '1;
        end else begin
            if (do_load) begin
                bin  <= cur[6:0];
                over <= (cur >= 32'd100);
                bcd  <= '0;
                nsh  <= '0;
            end
            if (do_shift) begin
                {bcd, bin} <= {adj[6:0], bin, 1'b0};
                nsh        <= nsh + 3'd1;
            end
            if (do_store) begin
                for (int j = 0; j < N_DISP; j++) begin
                    if (ch == 3'(j)) begin
                        hex_q[14*j +: 14] <= over ? {DASH, DASH} :
                            {seg(bcd[7:4]), seg(bcd[3:0])};
                    end
                end
                ch <= (ch == 3'(N_DISP - 1)) ? 3'd0 : ch + 3'd1;
            end
        end
    end

    assign hex = hex_q;

endmodule

// File: tb/tb_pipe_mmio_ctrl.sv
// Self-checking bench for pipe_mmio_ctrl: directed scenarios plus random
// bus/switch traffic compared every cycle against a behavioural model.
module tb_pipe_mmio_ctrl;

    localparam int N_SW = 4;
    localparam int N_DISP = 3;
    localparam int DEB = 16;
    localparam logic [6:0] DASH = 7'b0111111;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [N_SW-1:0]       sw;
    logic [N_SW-1:0]       led;
    logic [14*N_DISP-1:0]  hex;

    pipe_mmio_ctrl_if bus ();

    pipe_mmio_ctrl #(
        .N_SW(N_SW),
        .N_DISP(N_DISP),
        .DEB_CYCLES(DEB),
        .TOGGLE_INIT('0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sw(sw),
        .bus(bus),
        .led(led),
        .hex(hex)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    bit                    m_valid = 1'b0;
    logic [N_SW-1:0]       m_raw1, m_raw2;
    logic [N_SW-1:0]       m_stable, m_tog, m_ev;
    int                    m_run [N_SW];
    logic [31:0]           m_out [N_DISP];
    logic [31:0]           m_rdata;
    logic [14*N_DISP-1:0]  m_hex;
    logic [31:0]           m_cap;
    int                    m_k;

    logic [6:0] pats [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                              7'b0110000, 7'b0011001, 7'b0010010,
                              7'b0000010, 7'b1111000, 7'b0000000,
                              7'b0010000};

    function automatic logic [13:0] disp(input logic [31:0] v);
        if (v >= 100) return {DASH, DASH};
        return {pats[v / 10], pats[v % 10]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp,
                     $time);
        end
    endtask

    // Advance the model by one rising edge using the pre-edge inputs
    task automatic model_edge();
        int w;
        int ph;
        int c;
        logic [31:0] rv;
        logic [N_SW-1:0] fall;
        if (reset) begin
            m_raw1 = '1; m_raw2 = '1;
            m_stable = '1; m_tog = '0; m_ev = '0;
            for (int i = 0; i < N_SW; i++) m_run[i] = 0;
            for (int j = 0; j < N_DISP; j++) m_out[j] = '0;
            m_rdata = '0; m_hex = '1; m_cap = '0; m_k = 0;
            m_valid = 1'b1;
            return;
        end
        w = int'(bus.addr[7:2]);
        rv = '0;
        if (w < N_SW) rv = {31'b0, m_tog[w]};
        else if (w == 16) rv = 32'(m_ev);
        else if (w >= 32 && w < 32 + N_DISP) rv = m_out[w-32];
        // a level is accepted after DEB consecutive differing samples
        fall = '0;
        for (int i = 0; i < N_SW; i++) begin
            if (m_raw2[i] != m_stable[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_stable[i] = m_raw2[i];
                    m_run[i] = 0;
                    if (!m_raw2[i]) fall[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_k++;
        ph = (m_k - 1) % 9;
        c  = ((m_k - 1) / 9) % N_DISP;
        if (ph == 0) m_cap = m_out[c];
        if (ph == 8) m_hex[14*c +: 14] = disp(m_cap);
        if (bus.we && w >= 32 && w < 32 + N_DISP) m_out[w-32] = bus.wdata;
        if (bus.re) m_rdata = rv;
        if (bus.re && w == 16) m_ev = '0;
        m_ev  = m_ev | fall;
        m_tog = m_tog ^ fall;
        m_raw2 = m_raw1;
        m_raw1 = sw;
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        if (m_valid) begin
            chk("rdata", 64'(bus.rdata), 64'(m_rdata));
            chk("led", 64'(led), 64'(m_tog));
            chk("hex", 64'(hex), 64'(m_hex));
        end
    endtask

    task automatic idle();
        bus.re = 1'b0;
        bus.we = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.we = 1'b1;
        bus.addr = a;
        bus.wdata = d;
        step();
        idle();
    endtask

    task automatic rd(input logic [7:0] a);
        bus.re = 1'b1;
        bus.addr = a;
        step();
        idle();
    endtask

    initial begin
        int idx;
        reset = 1'b1;
        sw = '1;
        idle();
        step();
        step();
        chk("lit_rst_hex", 64'(hex), 64'({14*N_DISP{1'b1}}));
        chk("lit_rst_rdata", 64'(bus.rdata), 64'd0);
        reset = 1'b0;

        repeat (9 * N_DISP) step();
        chk("lit_zero", 64'(hex), 64'({N_DISP{14'b1000000_1000000}}));

        wr(8'h80, 32'd42);
        wr(8'h84, 32'd7);
        repeat (9 * N_DISP + 9) step();
        chk("lit_42", 64'(hex[13:0]), 64'({7'b0011001, 7'b0100100}));
        chk("lit_7", 64'(hex[27:14]), 64'({7'b1000000, 7'b1111000}));
        rd(8'h80);
        chk("lit_rd42", 64'(bus.rdata), 64'd42);

        wr(8'h88, 32'd100);
        repeat (9 * N_DISP + 9) step();
        chk("lit_100", 64'(hex[41:28]), 64'({DASH, DASH}));
        wr(8'h88, 32'hFFFF0063);
        repeat (9 * N_DISP + 9) step();
        chk("lit_big", 64'(hex[41:28]), 64'({DASH, DASH}));
        wr(8'h88, 32'd99);
        repeat (9 * N_DISP + 9) step();
        chk("lit_99", 64'(hex[41:28]), 64'({7'b0010000, 7'b0010000}));

        // short bounce must be ignored
        sw[1] = 1'b0;
        repeat (DEB - 2) step();
        sw[1] = 1'b1;
        repeat (DEB + 4) step();
        chk("lit_bounce", 64'(led), 64'd0);

        // real press: toggle exactly 2+DEB edges after the raw edge
        sw[1] = 1'b0;
        repeat (DEB + 1) step();
        chk("lit_pre_tog", 64'(led[1]), 64'd0);
        step();
        chk("lit_tog", 64'(led[1]), 64'd1);
        repeat (3) step();
        sw[1] = 1'b1;
        rd(8'h04);
        chk("lit_rd04", 64'(bus.rdata), 64'd1);
        rd(8'h40);
        chk("lit_ev1", 64'(bus.rdata), 64'h2);
        rd(8'h40);
        chk("lit_ev_clr", 64'(bus.rdata), 64'h0);
        repeat (DEB + 6) step();

        // event read lands on the same edge as the second press
        sw[1] = 1'b0;
        repeat (DEB + 1) step();
        rd(8'h40);
        chk("lit_race_rd", 64'(bus.rdata), 64'h0);
        chk("lit_race_led", 64'(led[1]), 64'd0);
        rd(8'h40);
        chk("lit_race_ev", 64'(bus.rdata), 64'h2);
        rd(8'h40);
        chk("lit_race_clr", 64'(bus.rdata), 64'h0);
        sw[1] = 1'b1;
        repeat (DEB + 4) step();

        rd(8'h3C);
        chk("lit_unmapped", 64'(bus.rdata), 64'd0);
        wr(8'hC0, 32'd5);
        rd(8'h80);
        chk("lit_c0_ign", 64'(bus.rdata), 64'd42);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 11) == 0) begin
                idx = $urandom_range(0, N_SW - 1);
                sw[idx] = ~sw[idx];
            end
            bus.re = ($urandom_range(0, 2) == 0);
            bus.we = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: bus.addr = 8'($urandom_range(0, 255));
                1: bus.addr = 8'(4 * $urandom_range(0, N_SW));
                2: bus.addr = 8'h40;
                default: bus.addr = 8'(8'h80 + 4 * $urandom_range(0, N_DISP));
            endcase
            bus.addr[1:0] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                bus.wdata = 32'($urandom_range(0, 120));
            else
                bus.wdata = $urandom;
            step();
        end
        idle();
        sw = '1;
        repeat (DEB + 4) step();

        // reset mid-SHIFT with toggle state and an output reg set
        wr(8'h80, 32'd55);
        sw[0] = 1'b0;
        repeat (DEB + 3) step();
        sw[0] = 1'b1;
        for (int i = 0; i < 20 && (m_k % 9) != 4; i++) step();
        chk("phase_wait", 64'(m_k % 9), 64'd4);
        reset = 1'b1;
        step();
        chk("lit_mid_hex", 64'(hex), 64'({14*N_DISP{1'b1}}));
        chk("lit_mid_led", 64'(led), 64'd0);
        chk("lit_mid_rdata", 64'(bus.rdata), 64'd0);
        reset = 1'b0;
        rd(8'h80);
        chk("lit_mid_out", 64'(bus.rdata), 64'd0);
        repeat (9 * N_DISP) step();
        chk("lit_mid_zero", 64'(hex), 64'({N_DISP{14'b1000000_1000000}}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
